// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter that shares one SPI master among several requesters.
// Latches the winner's word, starts the master, and returns its reply or a timeout error.
module spi_master_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int bits_size = 8,
   parameter int TIMEOUT   = 1023
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*bits_size-1:0] req_data,
   output logic [NUM_REQ-1:0]           gnt,
   output logic [NUM_REQ-1:0]           rsp_valid,
   output logic [bits_size-1:0]         rsp_data,
   output logic                         rsp_err,
   output logic                         busy,
   output logic [bits_size-1:0]         spi_data_in,
   output logic                         spi_tx_start,
   input  logic [bits_size-1:0]         spi_data_out,
   input  logic                         spi_rx_done
);

   localparam int              IW      = $clog2(NUM_REQ);
   localparam logic [IW:0]     NREQ    = (IW+1)'(NUM_REQ);
   localparam logic [IW-1:0]   LAST    = IW'(NUM_REQ-1);
   localparam logic [15:0]     TO_LAST = 16'(TIMEOUT-1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT,
      S_START,
      S_WAIT,
      S_DONE
   } state_t;

   state_t               state;
   logic [IW-1:0]        ptr;
   logic [IW-1:0]        win_q;
   logic [IW-1:0]        win_c;
   logic                 found_c;
   logic [IW:0]          scan_idx;
   logic [bits_size-1:0] slice_c;
   logic [15:0]          cnt;

   // First requesting index at or above the pointer, wrapping to zero.
   always_comb begin
      win_c    = '0;
      found_c  = 1'b0;
      scan_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = {1'b0, ptr} + (IW+1)'(k);
         if (scan_idx >= NREQ)
            scan_idx = scan_idx - NREQ;
         if (!found_c && req[scan_idx[IW-1:0]]) begin
            found_c = 1'b1;
            win_c   = scan_idx[IW-1:0];
         end
      end
   end

   // Transmit word of the registered winner.
   always_comb begin
      slice_c = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (win_q == IW'(k))
            slice_c = req_data[k*bits_size +: bits_size];
   end

   // Sequencer: grant, start the master, wait for done or timeout, respond.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         ptr          <= '0;
         win_q        <= '0;
         cnt          <= '0;
         gnt          <= '0;
         rsp_valid    <= '0;
         rsp_data     <= '0;
         rsp_err      <= 1'b0;
         busy         <= 1'b0;
         spi_data_in  <= '0;
         spi_tx_start <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (found_c) begin
                  win_q <= win_c;
                  gnt   <= NUM_REQ'(1) << win_c;
                  busy  <= 1'b1;
                  state <= S_GRANT;
               end
            end
            S_GRANT: begin
               spi_data_in  <= slice_c;
               spi_tx_start <= 1'b1;
               state        <= S_START;
            end
            S_START: begin
               spi_tx_start <= 1'b0;
               cnt          <= '0;
               state        <= S_WAIT;
            end
            S_WAIT: begin
               if (spi_rx_done) begin
                  rsp_data  <= spi_data_out;
                  rsp_err   <= 1'b0;
                  rsp_valid <= gnt;
                  state     <= S_DONE;
               end else if (cnt == TO_LAST) begin
                  rsp_data  <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= gnt;
                  state     <= S_DONE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_DONE: begin
               rsp_valid <= '0;
               gnt       <= '0;
               busy      <= 1'b0;
               ptr       <= (win_q == LAST) ? '0 : win_q + 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Testbench for spi_master_arbiter: directed scenarios plus randomized
// transfers checked against a round-robin reference model.
module tb_spi_master_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  gnt;
   logic [3:0]  rsp_valid;
   logic [7:0]  rsp_data;
   logic        rsp_err;
   logic        busy;
   logic [7:0]  spi_data_in;
   logic        spi_tx_start;
   logic [7:0]  spi_data_out = '0;
   logic        spi_rx_done = 1'b0;

   int errors = 0;
   int checks = 0;
   int m_ptr  = 0;

   spi_master_arbiter #(
      .NUM_REQ   (4),
      .bits_size (8),
      .TIMEOUT   (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .req_data     (req_data),
      .gnt          (gnt),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .rsp_err      (rsp_err),
      .busy         (busy),
      .spi_data_in  (spi_data_in),
      .spi_tx_start (spi_tx_start),
      .spi_data_out (spi_data_out),
      .spi_rx_done  (spi_rx_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: first requester at or after the pointer, circularly.
   function automatic int pick(input logic [3:0] r);
      int idx;
      for (int k = 0; k < 4; k++) begin
         idx = (m_ptr + k) % 4;
         if (((r >> idx) & 4'd1) == 4'd1)
            return idx;
      end
      return -1;
   endfunction

   // Runs one transfer from IDLE and reports what was observed.
   task automatic run_xfer(
      input  logic [3:0]  r,
      input  logic [3:0]  r_mid,
      input  logic [31:0] d,
      input  int          dly,
      input  bit          give,
      input  logic [7:0]  rx,
      output logic [3:0]  o_gnt,
      output int          o_st,
      output logic [7:0]  o_din,
      output int          o_starts,
      output int          o_lat,
      output logic [3:0]  o_vld,
      output logic [7:0]  o_rdata,
      output logic        o_err,
      output logic        o_busy,
      output logic [3:0]  o_after
   );
      int s;
      s = -1;
      o_st = -1; o_din = '0; o_starts = 0; o_lat = -1;
      o_vld = '0; o_rdata = '0; o_err = 1'b0;
      req = r;
      req_data = d;
      tick();
      o_gnt = gnt;
      for (int c = 1; c <= 60; c++) begin
         spi_rx_done = give && (s >= 0) && (c == s + dly);
         spi_data_out = spi_rx_done ? rx : 8'($urandom);
         tick();
         if (spi_tx_start) begin
            o_starts++;
            if (s < 0) begin
               s = c;
               o_st = c;
               o_din = spi_data_in;
               req = r_mid;
            end
         end
         if (rsp_valid != 4'd0) begin
            o_vld = rsp_valid;
            o_rdata = rsp_data;
            o_err = rsp_err;
            o_lat = c - s;
            break;
         end
      end
      spi_rx_done = 1'b0;
      req = '0;
      tick();
      o_busy = busy;
      o_after = rsp_valid | gnt;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req = '0;
      tick();
      tick();
      reset = 1'b0;
      m_ptr = 0;
      checks++;
      if ({gnt, rsp_valid, rsp_err, busy, spi_tx_start} !== 11'd0) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 0",
                  {gnt, rsp_valid, rsp_err, busy, spi_tx_start});
      end
      checks++;
      if (rsp_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_rsp_data got %h want 00", rsp_data);
      end
      checks++;
      if (spi_data_in !== 8'h00) begin
         errors++;
         $display("FAIL reset_spi_data_in got %h want 00", spi_data_in);
      end
   endtask

   task automatic test_single();
      logic [3:0] g, v, a;
      logic [7:0] din, rd;
      logic       e, b;
      int         st, ns, lat;
      run_xfer(4'b0010, 4'b0010, 32'h0000_A500, 3, 1'b1, 8'h3C,
               g, st, din, ns, lat, v, rd, e, b, a);
      m_ptr = 2;
      checks++;
      if (g !== 4'b0010) begin
         errors++; $display("FAIL single_gnt got %b want 0010", g);
      end
      checks++;
      if (st !== 1) begin
         errors++; $display("FAIL single_start_lat got %0d want 1", st);
      end
      checks++;
      if (ns !== 1) begin
         errors++; $display("FAIL single_start_pulses got %0d want 1", ns);
      end
      checks++;
      if (din !== 8'hA5) begin
         errors++; $display("FAIL single_din got %h want a5", din);
      end
      checks++;
      if (v !== 4'b0010 || lat !== 3) begin
         errors++;
         $display("FAIL single_rsp got vld=%b lat=%0d want 0010 lat=3", v, lat);
      end
      checks++;
      if (rd !== 8'h3C || e !== 1'b0) begin
         errors++;
         $display("FAIL single_data got %h err=%b want 3c err=0", rd, e);
      end
      checks++;
      if (b !== 1'b0 || a !== 4'd0) begin
         errors++;
         $display("FAIL single_after got busy=%b vld|gnt=%b want 0", b, a);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0]  g, v, a, eg;
      logic [7:0]  din, rd, rx;
      logic [31:0] d;
      logic        e, b;
      int          st, ns, lat, w;
      int          order [6] = '{0, 1, 2, 3, 0, 1};
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_ptr = 0;
      for (int i = 0; i < 6; i++) begin
         d = $urandom;
         rx = 8'($urandom);
         w = pick(4'b1111);
         eg = 4'b0001 << order[i];
         run_xfer(4'b1111, 4'b1111, d, 4, 1'b1, rx,
                  g, st, din, ns, lat, v, rd, e, b, a);
         m_ptr = (w + 1) % 4;
         checks++;
         if (g !== eg || v !== eg) begin
            errors++;
            $display("FAIL rr_gnt[%0d] got gnt=%b vld=%b want %b", i, g, v, eg);
         end
         checks++;
         if (din !== 8'(d >> (order[i] * 8))) begin
            errors++;
            $display("FAIL rr_din[%0d] got %h want %h", i, din,
                     8'(d >> (order[i] * 8)));
         end
         checks++;
         if (rd !== rx) begin
            errors++; $display("FAIL rr_data[%0d] got %h want %h", i, rd, rx);
         end
      end
   endtask

   task automatic test_pointer_wrap();
      logic [3:0] g, v, a;
      logic [7:0] din, rd;
      logic       e, b;
      int         st, ns, lat;
      run_xfer(4'b0100, 4'b0100, 32'h1122_3344, 2, 1'b1, 8'h01,
               g, st, din, ns, lat, v, rd, e, b, a);
      m_ptr = 3;
      checks++;
      if (g !== 4'b0100) begin
         errors++; $display("FAIL wrap_first got %b want 0100", g);
      end
      run_xfer(4'b0101, 4'b0101, 32'h1122_3344, 2, 1'b1, 8'h02,
               g, st, din, ns, lat, v, rd, e, b, a);
      m_ptr = 1;
      checks++;
      if (g !== 4'b0001) begin
         errors++; $display("FAIL wrap_second got %b want 0001", g);
      end
      run_xfer(4'b0101, 4'b0101, 32'h1122_3344, 2, 1'b1, 8'h03,
               g, st, din, ns, lat, v, rd, e, b, a);
      m_ptr = 3;
      checks++;
      if (g !== 4'b0100) begin
         errors++; $display("FAIL wrap_third got %b want 0100", g);
      end
   endtask

   task automatic test_timeout();
      logic [3:0] g, v, a;
      logic [7:0] din, rd;
      logic       e, b;
      int         st, ns, lat;
      run_xfer(4'b0001, 4'b0001, 32'h0000_00EE, 0, 1'b0, 8'h00,
               g, st, din, ns, lat, v, rd, e, b, a);
      m_ptr = 1;
      checks++;
      if (v !== 4'b0001 || lat !== 17) begin
         errors++;
         $display("FAIL timeout_lat got vld=%b lat=%0d want 0001 lat=17", v, lat);
      end
      checks++;
      if (e !== 1'b1 || rd !== 8'h00) begin
         errors++;
         $display("FAIL timeout_err got err=%b data=%h want err=1 data=00", e, rd);
      end
      checks++;
      if (b !== 1'b0) begin
         errors++; $display("FAIL timeout_busy got %b want 0", b);
      end
   endtask

   task automatic test_collision();
      logic [3:0] g, v, a;
      logic [7:0] din, rd;
      logic       e, b;
      int         st, ns, lat;
      run_xfer(4'b0010, 4'b0010, 32'h0000_5500, 17, 1'b1, 8'h77,
               g, st, din, ns, lat, v, rd, e, b, a);
      m_ptr = 2;
      checks++;
      if (v !== 4'b0010 || lat !== 17) begin
         errors++;
         $display("FAIL collide_lat got vld=%b lat=%0d want 0010 lat=17", v, lat);
      end
      checks++;
      if (e !== 1'b0 || rd !== 8'h77) begin
         errors++;
         $display("FAIL collide_data got err=%b data=%h want err=0 data=77", e, rd);
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [3:0] g, v, a;
      logic [7:0] din, rd;
      logic       e, b;
      int         st, ns, lat;
      int         stray;
      req = 4'b0100;
      req_data = 32'h00AB_0000;
      for (int i = 0; i < 5; i++)
         tick();
      checks++;
      if (busy !== 1'b1 || gnt !== 4'b0100) begin
         errors++;
         $display("FAIL midwait_busy got busy=%b gnt=%b want 1 0100", busy, gnt);
      end
      reset = 1'b1;
      req = '0;
      tick();
      reset = 1'b0;
      m_ptr = 0;
      checks++;
      if ({gnt, rsp_valid, rsp_err, busy, spi_tx_start} !== 11'd0 ||
          rsp_data !== 8'h00 || spi_data_in !== 8'h00) begin
         errors++;
         $display("FAIL midwait_reset got ctrl=%b data=%h din=%h want 0",
                  {gnt, rsp_valid, rsp_err, busy, spi_tx_start},
                  rsp_data, spi_data_in);
      end
      spi_rx_done = 1'b1;
      spi_data_out = 8'h55;
      tick();
      spi_rx_done = 1'b0;
      stray = 0;
      for (int i = 0; i < 3; i++) begin
         if (rsp_valid != 4'd0 || busy)
            stray++;
         tick();
      end
      checks++;
      if (stray !== 0) begin
         errors++; $display("FAIL stray_done got %0d events want 0", stray);
      end
      run_xfer(4'b1111, 4'b1111, 32'h4433_2211, 2, 1'b1, 8'h9A,
               g, st, din, ns, lat, v, rd, e, b, a);
      m_ptr = 1;
      checks++;
      if (g !== 4'b0001 || din !== 8'h11) begin
         errors++;
         $display("FAIL midwait_ptr got gnt=%b din=%h want 0001 11", g, din);
      end
      run_xfer(4'b1000, 4'b1000, 32'hC300_0000, 5, 1'b1, 8'h5A,
               g, st, din, ns, lat, v, rd, e, b, a);
      m_ptr = 0;
      checks++;
      if (g !== 4'b1000 || v !== 4'b1000 || rd !== 8'h5A || e !== 1'b0) begin
         errors++;
         $display("FAIL midwait_next got gnt=%b vld=%b data=%h err=%b want 1000 1000 5a 0",
                  g, v, rd, e);
      end
   endtask

   task automatic test_random();
      logic [3:0]  g, v, a, r, rm, eg;
      logic [7:0]  din, rd, rx, erd;
      logic [31:0] d;
      logic        e, b, eerr, give;
      int          st, ns, lat, w, dly, elat;
      for (int i = 0; i < 24; i++) begin
         r = 4'($urandom_range(1, 15));
         rm = 4'($urandom);
         d = $urandom;
         rx = 8'($urandom);
         dly = $urandom_range(1, 20);
         give = ($urandom_range(0, 4) != 0);
         w = pick(r);
         eg = 4'b0001 << w;
         eerr = !(give && dly >= 2 && dly <= 17);
         elat = eerr ? 17 : dly;
         erd = eerr ? 8'h00 : rx;
         run_xfer(r, rm, d, dly, give, rx,
                  g, st, din, ns, lat, v, rd, e, b, a);
         m_ptr = (w + 1) % 4;
         checks++;
         if (g !== eg || v !== eg) begin
            errors++;
            $display("FAIL rand_gnt[%0d] got gnt=%b vld=%b want %b", i, g, v, eg);
         end
         checks++;
         if (din !== 8'(d >> (w * 8)) || ns !== 1) begin
            errors++;
            $display("FAIL rand_start[%0d] got din=%h pulses=%0d want %h 1",
                     i, din, ns, 8'(d >> (w * 8)));
         end
         checks++;
         if (lat !== elat) begin
            errors++;
            $display("FAIL rand_lat[%0d] got %0d want %0d", i, lat, elat);
         end
         checks++;
         if (rd !== erd || e !== eerr) begin
            errors++;
            $display("FAIL rand_rsp[%0d] got data=%h err=%b want %h %b",
                     i, rd, e, erd, eerr);
         end
         checks++;
         if (b !== 1'b0 || a !== 4'd0) begin
            errors++;
            $display("FAIL rand_after[%0d] got busy=%b vld|gnt=%b want 0", i, b, a);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_pointer_wrap();
      test_timeout();
      test_collision();
      test_reset_mid_wait();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
Round-robin arbiter and sequencer that shares one SPI_Master instance among NUM_REQ on-chip requesters. It latches the winning requester's transmit word and pulses tx_start to the master. It waits for the master's receive-done, then returns the received word to the winner with a one-cycle response strobe. A watchdog aborts transfers whose done never arrives.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
bits_size, 8, SPI word width; matches SPI_Master bits_size
TIMEOUT, 1023, max cycles in WAIT before abort (1..65535)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester request level; held until its rsp_valid bit
req_data  input  NUM_REQ*bits_size  tx words; requester i at [i*bits_size +: bits_size]
gnt  output  NUM_REQ  one-hot grant; high from GRANT through DONE for the winner
rsp_valid  output  NUM_REQ  one-hot, one-cycle response strobe to the winner
rsp_data  output  bits_size  received word; valid when any rsp_valid bit is set
rsp_err  output  1  high with rsp_valid when the transfer timed out
busy  output  1  high in every state except IDLE
spi_data_in  output  bits_size  to SPI_Master data_in; held stable START..DONE
spi_tx_start  output  1  to SPI_Master tx_start; single-cycle pulse
spi_data_out  input  bits_size  from SPI_Master data_out
spi_rx_done  input  1  from SPI_Master rx_done; single-cycle pulse

Behaviour:
- Reset (synchronous, reset=1 at clk edge): state=IDLE; gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, spi_data_in=0, spi_tx_start=0; round-robin pointer=0; timeout counter=0. Reset overrides any in-flight transfer.
- After reset mid-transfer, spi_rx_done is ignored until the next START. The SPI_Master shares this reset.
- All outputs are registered.
- FSM states: IDLE, GRANT, START, WAIT, DONE.
- IDLE -> GRANT when req!=0.
  - Winner is the first set bit of req, searching upward from pointer, wrapping NUM_REQ-1 -> 0.
  - Register the winner index; set its gnt bit.
- GRANT -> START: latch the winner's req_data slice into spi_data_in.
- START: spi_tx_start=1 for exactly this cycle; clear timeout counter. Then -> WAIT.
- WAIT:
  - On spi_rx_done=1: capture spi_data_out into rsp_data, rsp_err=0, -> DONE.
  - Otherwise increment the counter. When counter==TIMEOUT-1 without done: rsp_data=0, rsp_err=1, -> DONE.
  - If done arrives on the same cycle as the timeout, done wins (rsp_err=0).
- DONE:
  - rsp_valid[winner]=1 for one cycle. gnt stays set this cycle and clears next.
  - pointer = (winner+1) mod NUM_REQ.
  - -> IDLE.
- Latency: req high in IDLE at edge n -> gnt at n+1 -> spi_tx_start at n+2. spi_rx_done at edge m -> rsp_valid at m+1. Minimum gap between transfers is 2 cycles (DONE, IDLE).
- Requests:
  - req changes of non-winners during a transfer do not affect the transfer.
  - Winner dropping req before rsp_valid is a protocol violation; the transfer still completes and rsp_valid is still issued.
- spi_rx_done outside WAIT is ignored.
- Fairness: with all requests continuously asserted, grants rotate 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transfers.
- rsp_err and rsp_data keep their last values until the next DONE. rsp_valid gates their use.

Test Plan:
1. Single requester: reset, req=4'b0010, req_data[15:8]=8'hA5; model returns 8'h3C. Expect:
   - gnt=0010 one cycle after req;
   - spi_tx_start one pulse with spi_data_in=A5;
   - rsp_valid=0010 with rsp_data=3C, rsp_err=0, one cycle after spi_rx_done.
2. Round-robin: req=4'b1111 held, each requester re-asserting after rsp_valid. Expect grant order 0,1,2,3,0,1 across six transfers. Each spi_data_in matches the granted slice.
3. Pointer wrap: pointer at 3 after granting 2; req=4'b0101. Expect grant to 0, then 2, never 2 twice in a row.
4. Timeout: TIMEOUT=16; model never asserts spi_rx_done. Expect:
   - rsp_valid with rsp_err=1, rsp_data=0 exactly 16 cycles after the spi_tx_start cycle (+1 for DONE);
   - busy returns to 0 the following cycle.
5. Done/timeout collision: spi_rx_done on the final timeout cycle with data 8'h77. Expect rsp_err=0, rsp_data=77.
6. Reset mid-WAIT: assert reset during WAIT, then release. Expect:
   - all outputs 0 and pointer=0;
   - a stray spi_rx_done produces no rsp_valid;
   - next req=4'b1000 is granted normally.
